scale_acc: RTL
==============

SCALE_ACC -- requirements
Module: scale_acc

Interface
REQ-001 Parameter DATA_W, default 8, width of each scaled sample from the scaler stage.
REQ-002 Parameter LEN_W, default 3, width of the burst-length field; burst holds 1..2**LEN_W samples.
REQ-003 Parameter ACC_W, default DATA_W+LEN_W (11), accumulator width; sized so no overflow is possible.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clr  input  1  synchronous abort; discards the burst in progress.
REQ-007 len  input  LEN_W  burst length minus one; sampled only on the first accepted sample of a burst.
REQ-008 in_valid  input  1  in_data is valid this cycle.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 in_data  input  DATA_W  unsigned scaled sample (the scaler's 8-bit output o).
REQ-011 out_valid  output  1  out_sum holds a completed burst sum.
REQ-012 out_ready  input  1  consumer takes out_sum this cycle.
REQ-013 out_sum  output  ACC_W  unsigned sum of the burst.
REQ-014 out_cnt  output  LEN_W+1  number of samples in out_sum (len_q+1).

Function
REQ-015 A sample is accepted when in_valid && in_ready at a rising edge; a result is taken when out_valid && out_ready.
REQ-016 FSM states: IDLE, ACC, DONE; in_ready=1 in IDLE and ACC, 0 in DONE; out_valid=1 only in DONE.
REQ-017 IDLE, sample accepted: len_q<=len, acc<=zero-extended in_data, cnt<=1; next DONE if len==0, else ACC.
REQ-018 ACC, sample accepted: acc<=acc+in_data, cnt<=cnt+1; next DONE when cnt+1==len_q+1, else stay ACC.
REQ-019 ACC/IDLE with no accepted sample: all state held; gaps of any length between samples are legal.
REQ-020 DONE: out_sum=acc, out_cnt=cnt, both stable while out_valid && !out_ready; on take, next IDLE, acc<=0, cnt<=0.
REQ-021 Latency: out_valid rises the cycle after the final sample is accepted; peak throughput one burst per len+2 cycles.
REQ-022 len changes after the first sample of a burst have no effect on that burst.
REQ-023 clr=1 in any state: next IDLE, acc<=0, cnt<=0, out_valid drops next cycle; a sample or take in the same cycle is discarded/ignored (clr wins).
REQ-024 Arithmetic is unsigned, ACC_W wide; maximum sum (2**LEN_W)*(2**DATA_W-1) = 2040 fits without wrap.
REQ-025 in_ready and out_valid are decoded from registered state only; no combinational path from in_valid or out_ready to them.

Reset
REQ-026 rst asserted: state=IDLE, acc=0, cnt=0, len_q=0 immediately, without waiting for clk.
REQ-027 Outputs during/after reset: in_ready=1, out_valid=0, out_sum=0, out_cnt=0.
REQ-028 rst mid-burst or in DONE discards the partial/pending sum; first cycle after release behaves as IDLE.

Structure
REQ-029 Shared package scale_pkg holds DATA_W/LEN_W/ACC_W defaults and the state enum type (IDLE, ACC, DONE).
REQ-030 No sub-module; FSM, accumulator and counter live in scale_acc; the scaler instance stays outside.

Verification
REQ-031 len=0, one sample 8'd200 -> next cycle out_valid=1, out_sum=200, out_cnt=1; out_ready=1 -> IDLE.
REQ-032 len=3, samples 10,20,30,40 with 2-cycle gaps in between -> out_sum=100, out_cnt=4, in_ready=0 while DONE.
REQ-033 len=7, eight samples 255 back-to-back -> out_sum=2040, out_cnt=8, no wrap.
REQ-034 DONE with out_ready=0 for 5 cycles while in_valid=1 -> out_sum held at its value, no sample accepted, in_ready=0.
REQ-035 len=3, two samples, then clr=1 with in_valid=1 -> IDLE, sample dropped; next burst len=0, sample 5 -> out_sum=5.
REQ-036 rst asserted between clock edges mid-burst -> out_valid=0, in_ready=1 at once; fresh burst len=1, samples 3,4 -> out_sum=7.

Source files
------------

// File: rtl/scale_pkg.sv
// Shared defaults and state encoding for the scaled-sample burst accumulator.
package scale_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 3;
    localparam int DEF_ACC_W  = DEF_DATA_W + DEF_LEN_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/scale_acc.sv
// Sums a burst of 1..2**LEN_W unsigned scaled samples and presents the total
// with a valid/ready handshake; clr aborts the burst in progress.
module scale_acc
    import scale_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int ACC_W  = DATA_W + LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [LEN_W:0]    out_cnt
);

    state_t             r_state;
    state_t             w_next;
    logic [ACC_W-1:0]   r_acc;
    logic [LEN_W:0]     r_cnt;
    logic [LEN_W-1:0]   r_len;

    logic               w_accept;
    logic               w_take;
    logic [LEN_W:0]     w_cntInc;
    logic [LEN_W:0]     w_lenP1;
    logic [ACC_W-1:0]   w_dataExt;

    // Handshake flags come from registered state only, never from in_valid/out_ready.
    assign in_ready  = (r_state != DONE);
    assign out_valid = (r_state == DONE);
    assign out_sum   = r_acc;
    assign out_cnt   = r_cnt;

    assign w_accept  = in_valid && in_ready;
    assign w_take    = out_valid && out_ready;
    assign w_cntInc  = r_cnt + (LEN_W+1)'(1);
    assign w_lenP1   = {1'b0, r_len} + (LEN_W+1)'(1);
    assign w_dataExt = ACC_W'(in_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (clr) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_next = (len == '0) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (w_accept && (w_cntInc == w_lenP1)) begin
                        w_next = DONE;
                    end
                end
                DONE: begin
                    if (w_take) begin
                        w_next = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Burst length is latched on the first sample so later len changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_len <= '0;
        end else if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_len <= len;
                        r_acc <= w_dataExt;
                        r_cnt <= (LEN_W+1)'(1);
                    end
                end
                ACC: begin
                    if (w_accept) begin
                        r_acc <= r_acc + w_dataExt;
                        r_cnt <= w_cntInc;
                    end
                end
                DONE: begin
                    if (w_take) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                default: begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule
